muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_iter_core.sv | 32 +++
 rtl/muldiv_sequencer.sv | 161 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative MIPS multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned MULDIV_WIDTH = 32;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_FIX  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/muldiv_iter_core.sv
// One combinational iteration: right-shifting shift-add multiply or
// left-shifting restoring divide on a 2*WIDTH+1 bit accumulator.
module muldiv_iter_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               is_div_i,
   input  logic [WIDTH-1:0]   operand_i,
   input  logic [2*WIDTH:0]   acc_i,
   output logic [2*WIDTH:0]   acc_o
);

   logic [2*WIDTH:0] shl;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   upper_add;

   always_comb begin
      shl       = {acc_i[2*WIDTH-1:0], 1'b0};
      trial     = shl[2*WIDTH:WIDTH] - {1'b0, operand_i};
      upper_add = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, operand_i} : '0);
      if (is_div_i) begin
         // Divide layout: {remainder[WIDTH:0], quotient/dividend[WIDTH-1:0]}
         acc_o = shl;
         if (shl[2*WIDTH:WIDTH] >= {1'b0, operand_i}) begin
            acc_o = {trial, shl[WIDTH-1:1], 1'b1};
         end
      end else begin
         // Multiply layout: {carry, product_hi, multiplier/product_lo}
         acc_o = {1'b0, upper_add, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/multu/div/divu sequencer owning HI/LO; stalls the pipe
// for WIDTH iterations plus one sign-fix cycle.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] Read_data_1,
   input  logic [WIDTH-1:0] Read_data_2,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned AccW = 2 * WIDTH + 1;

   state_t           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;
   logic             sign_a_q, sign_a_d;
   logic             div0_q, div0_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [AccW-1:0]  acc_q, acc_d, acc_step;

   logic             is_div_in, signed_in, sign_a_in, sign_b_in;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] fix_hi, fix_lo;
   logic             move_ok;

   assign is_div_in = (op == OP_DIVU) || (op == OP_DIV);
   assign signed_in = (op == OP_MULT) || (op == OP_DIV);
   assign sign_a_in = signed_in & Read_data_1[WIDTH-1];
   assign sign_b_in = signed_in & Read_data_2[WIDTH-1];
   assign mag_a     = sign_a_in ? -Read_data_1 : Read_data_1;
   assign mag_b     = sign_b_in ? -Read_data_2 : Read_data_2;

   muldiv_iter_core #(
      .WIDTH(WIDTH)
   ) u_iter (
      .is_div_i (is_div_q),
      .operand_i(opnd_q),
      .acc_i    (acc_q),
      .acc_o    (acc_step)
   );

   always_comb begin
      prod_fix = acc_q[2*WIDTH-1:0];
      if (neg_q) begin
         prod_fix = -acc_q[2*WIDTH-1:0];
      end
      if (is_div_q) begin
         fix_lo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         // Divide by zero leaves |A| as remainder; sign fix then restores raw A.
         if (div0_q) begin
            fix_lo = '1;
         end
         fix_hi = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      sign_a_d = sign_a_q;
      div0_d   = div0_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      move_ok  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               is_div_d = is_div_in;
               neg_d    = sign_a_in ^ sign_b_in;
               sign_a_d = sign_a_in;
               div0_d   = is_div_in && (Read_data_2 == '0);
               opnd_d   = is_div_in ? mag_b : mag_a;
               acc_d    = {{(WIDTH + 1){1'b0}}, (is_div_in ? mag_a : mag_b)};
               cnt_d    = '0;
               state_d  = ST_CALC;
            end else begin
               move_ok = 1'b1;
            end
         end
         ST_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            move_ok = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
      if (move_ok) begin
         if (mthi) begin
            hi_d = Read_data_1;
         end
         if (mtlo) begin
            lo_d = Read_data_1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         sign_a_q <= 1'b0;
         div0_q   <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         sign_a_q <= sign_a_d;
         div0_q   <= div0_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign done   = (state_q == ST_DONE);
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

   localparam int unsigned W = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  rd1;
   logic [W-1:0]  rd2;
   logic          mthi;
   logic          mtlo;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi_out;
   logic [W-1:0]  lo_out;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  m_hi;
   logic [W-1:0]  m_lo;

   always #5 clock = ~clock;

   muldiv_sequencer #(
      .WIDTH(W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .Read_data_1(rd1),
      .Read_data_2(rd2),
      .mthi       (mthi),
      .mtlo       (mtlo),
      .busy       (busy),
      .done       (done),
      .hi_out     (hi_out),
      .lo_out     (lo_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: MIPS HI/LO semantics from ordinary integer arithmetic.
   function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] h,
                                 output logic [31:0] l);
      logic [63:0] p;
      int          sa, sb, q, r;
      longint      lp;
      sa = a;
      sb = b;
      case (o)
         2'b00: begin
            p = {32'b0, a} * {32'b0, b};
            {h, l} = p;
         end
         2'b01: begin
            lp = longint'(sa) * longint'(sb);
            {h, l} = lp;
         end
         2'b10: begin
            if (b == 0) begin
               h = a;
               l = 32'hFFFF_FFFF;
            end else begin
               h = a % b;
               l = a / b;
            end
         end
         default: begin
            if (b == 0) begin
               h = a;
               l = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               h = 32'h0;
               l = 32'h8000_0000;
            end else begin
               q = sa / sb;
               r = sa % sb;
               h = r;
               l = q;
            end
         end
      endcase
   endfunction

   // Launches one operation, scribbles on inputs while busy, and checks
   // latency, stall length and the HI/LO result. Starts and ends on a negedge.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit mv_start, input bit mv_done, input logic [31:0] mv_val,
                         input string tag);
      logic [31:0] eh, el;
      int n, nb;
      model(o, a, b, eh, el);
      start = 1'b1;
      op    = o;
      rd1   = a;
      rd2   = b;
      mthi  = mv_start;
      mtlo  = mv_start;
      @(negedge clock);
      check({tag, "/hold_hi"}, hi_out, m_hi);
      check({tag, "/hold_lo"}, lo_out, m_lo);
      n  = 1;
      nb = 0;
      while (done !== 1'b1 && n < 60) begin
         if (busy === 1'b1) nb++;
         start = 1'($urandom);
         mthi  = 1'($urandom);
         mtlo  = 1'($urandom);
         op    = 2'($urandom);
         rd1   = $urandom;
         rd2   = $urandom;
         @(negedge clock);
         n++;
      end
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      check({tag, "/latency"}, 32'(n), 32'd34);
      check({tag, "/busy_cycles"}, 32'(nb), 32'd33);
      check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "/hi"}, hi_out, eh);
      check({tag, "/lo"}, lo_out, el);
      m_hi = eh;
      m_lo = el;
      if (mv_done) begin
         mthi = 1'b1;
         rd1  = mv_val;
         m_hi = mv_val;
      end
      @(negedge clock);
      mthi = 1'b0;
      check({tag, "/done_pulse"}, 32'(done), 32'd0);
      check({tag, "/after_hi"}, hi_out, m_hi);
      check({tag, "/after_lo"}, lo_out, m_lo);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] specials [5];
      specials[0] = 32'h0;
      specials[1] = 32'h1;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'h8000_0000;
      specials[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 40));
      return $urandom;
   endfunction

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      rd1   = '0;
      rd2   = '0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      repeat (2) @(negedge clock);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/done", 32'(done), 32'd0);
      check("reset/hi", hi_out, 32'h0);
      check("reset/lo", lo_out, 32'h0);
      reset = 1'b0;
      @(negedge clock);

      // Moves in IDLE, singly and together.
      rd1  = 32'h1234_5678;
      mthi = 1'b1;
      @(negedge clock);
      mthi = 1'b0;
      m_hi = 32'h1234_5678;
      check("mthi/hi", hi_out, m_hi);
      check("mthi/lo", lo_out, m_lo);
      rd1  = 32'hA5A5_0F0F;
      mthi = 1'b1;
      mtlo = 1'b1;
      @(negedge clock);
      mthi = 1'b0;
      mtlo = 1'b0;
      m_hi = 32'hA5A5_0F0F;
      m_lo = 32'hA5A5_0F0F;
      check("mthilo/hi", hi_out, m_hi);
      check("mthilo/lo", lo_out, m_lo);

      // Directed cases; start arrives with a move that must be dropped.
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, "multu_max");
      check("multu_max/hi_const", hi_out, 32'hFFFF_FFFE);
      check("multu_max/lo_const", lo_out, 32'h0000_0001);
      run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 32'h0, "mult_neg");
      check("mult_neg/hi_const", hi_out, 32'hFFFF_FFFF);
      check("mult_neg/lo_const", lo_out, 32'hFFFF_FFEB);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'h0, "div_neg");
      check("div_neg/hi_const", hi_out, 32'hFFFF_FFFF);
      check("div_neg/lo_const", lo_out, 32'hFFFF_FFFD);
      run_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b1, 32'hCAFE_F00D, "divu_zero");
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, "div_ovf");
      check("div_ovf/hi_const", hi_out, 32'h0);
      check("div_ovf/lo_const", lo_out, 32'h8000_0000);
      run_op(2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, 32'h0, "div_zero_neg");

      // Reset in the middle of CALC, with start/mthi pokes that must be ignored.
      start = 1'b1;
      op    = 2'b10;
      rd1   = 32'd100;
      rd2   = 32'd7;
      @(negedge clock);
      repeat (9) begin
         start = 1'b1;
         mthi  = 1'b1;
         rd1   = $urandom;
         @(negedge clock);
      end
      start = 1'b0;
      mthi  = 1'b0;
      check("midop/busy", 32'(busy), 32'd1);
      check("midop/hi", hi_out, m_hi);
      #2 reset = 1'b1;
      #1;
      m_hi = '0;
      m_lo = '0;
      check("async_rst/busy", 32'(busy), 32'd0);
      check("async_rst/done", 32'(done), 32'd0);
      check("async_rst/hi", hi_out, 32'h0);
      check("async_rst/lo", lo_out, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0, "restart");
      check("restart/hi_const", hi_out, 32'd2);
      check("restart/lo_const", lo_out, 32'd14);

      for (int i = 0; i < 20; i++) begin
         ro = 2'($urandom);
         ra = pick();
         rb = pick();
         run_op(ro, ra, rb, 1'($urandom), 1'($urandom), $urandom, $sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
